i2c_slave: RTL and testbench

// - I2C target on the same SCL/SDA bus driven by i2c_master; consumes its START/addr/data/STOP traffic.
// - Matches a fixed 7-bit address; delivers written bytes to the host side; returns host-supplied bytes on reads.
// - Open-drain SDA only (drives 0 or Z); bench/board supplies pull-up. SCL is input only; no clock stretching.

---
 rtl/i2c_slave.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: fixed 7-bit address, byte writes to the host side and host-supplied read bytes.
// Open-drain SDA (0 or Z only); SCL is input only, no clock stretching.
module i2c_slave #(
   parameter logic [6:0] SLV_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       busy
);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StAddr     = 3'd1;
   localparam logic [2:0] StAckAddr  = 3'd2;
   localparam logic [2:0] StWrData   = 3'd3;
   localparam logic [2:0] StAckWr    = 3'd4;
   localparam logic [2:0] StRdData   = 3'd5;
   localparam logic [2:0] StRdAck    = 3'd6;
   localparam logic [2:0] StWaitStop = 3'd7;

   // [0],[1] synchronizer stages, [2] history of the synced value
   logic [2:0] scl_q, sda_q;
   logic       scl_s, scl_p, sda_s, sda_p;
   logic       scl_rise, scl_fall, start_c, stop_c;

   logic [2:0] state_q, state_d;
   logic [3:0] bitcnt_q, bitcnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic       rw_q, rw_d;
   logic       ack_q, ack_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;
   logic       busy_q, busy_d;

   assign scl_s    = scl_q[1];
   assign scl_p    = scl_q[2];
   assign sda_s    = sda_q[1];
   assign sda_p    = sda_q[2];
   assign scl_rise = scl_s & ~scl_p;
   assign scl_fall = ~scl_s & scl_p;
   assign start_c  = scl_s & scl_p & sda_p & ~sda_s;
   assign stop_c   = scl_s & scl_p & ~sda_p & sda_s;

   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_q <= 3'b000;
         sda_q <= 3'b000;
      end else begin
         scl_q <= {scl_q[1:0], scl};
         sda_q <= {sda_q[1:0], sda};
      end
   end

   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      tx_sh_d    = tx_sh_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      busy_d     = busy_q;

      if (start_c) begin
         state_d  = StAddr;
         bitcnt_d = 4'd0;
         shift_d  = 8'h00;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (stop_c) begin
         state_d  = StIdle;
         bitcnt_d = 4'd0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            StAddr, StWrData: begin
               if (scl_rise && bitcnt_q != 4'd8) begin
                  shift_d  = {shift_q[6:0], sda_s};
                  bitcnt_d = bitcnt_q + 4'd1;
               end else if (scl_fall && bitcnt_q == 4'd8) begin
                  bitcnt_d = 4'd0;
                  if (state_q == StWrData) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_oe_d   = 1'b1;
                     state_d    = StAckWr;
                  end else if (shift_q[7:1] == SLV_ADDR) begin
                     rw_d     = shift_q[0];
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                     state_d  = StAckAddr;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = StWaitStop;
                  end
               end
            end
            StAckAddr: begin
               if (scl_fall) begin
                  if (rw_q) begin
                     // bit7 goes straight to the pin; the shifter keeps the rest MSB-aligned
                     tx_sh_d  = {tx_data[6:0], 1'b0};
                     tx_req_d = 1'b1;
                     sda_oe_d = ~tx_data[7];
                     bitcnt_d = 4'd1;
                     state_d  = StRdData;
                  end else begin
                     sda_oe_d = 1'b0;
                     bitcnt_d = 4'd0;
                     state_d  = StWrData;
                  end
               end
            end
            StAckWr: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = StWrData;
               end
            end
            StRdData: begin
               if (scl_fall) begin
                  if (bitcnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     bitcnt_d = 4'd0;
                     state_d  = StRdAck;
                  end else begin
                     sda_oe_d = ~tx_sh_q[7];
                     tx_sh_d  = {tx_sh_q[6:0], 1'b0};
                     bitcnt_d = bitcnt_q + 4'd1;
                  end
               end
            end
            StRdAck: begin
               if (scl_rise) begin
                  ack_d = sda_s;
               end else if (scl_fall) begin
                  if (!ack_q) begin
                     tx_sh_d  = {tx_data[6:0], 1'b0};
                     tx_req_d = 1'b1;
                     sda_oe_d = ~tx_data[7];
                     bitcnt_d = 4'd1;
                     state_d  = StRdData;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = StWaitStop;
                  end
               end
            end
            default: begin
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         bitcnt_q   <= 4'd0;
         shift_q    <= 8'h00;
         tx_sh_q    <= 8'h00;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         tx_sh_q    <= tx_sh_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: behavioural bus master on a pulled-up SDA, directed cases plus random
// transactions checked against a transaction-level expectation model.
module tb_i2c_slave;

   localparam int         Q    = 12;     // clk cycles per quarter SCL period
   localparam logic [6:0] ADDR = 7'h50;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl_drv = 1'b1;
   logic       m_low = 1'b0;
   wire        sda;
   logic [7:0] tx_data;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic       busy;

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_slave #(.SLV_ADDR(ADDR)) dut (
      .clk      (clk),
      .rst      (rst),
      .scl      (scl_drv),
      .sda      (sda),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_req   (tx_req),
      .busy     (busy)
   );

   int unsigned rx_cnt  = 0;
   int unsigned txr_cnt = 0;
   logic [7:0]  tx_stream [0:63];

   // tx_data always offers the next unread entry of the read stream
   assign tx_data = tx_stream[txr_cnt[5:0]];

   always @(negedge clk) begin
      if (rx_valid) rx_cnt++;
      if (tx_req) txr_cnt++;
   end

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic        bit_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_low = 1'b0; qwait();
      scl_drv = 1'b1; qwait();
      m_low = 1'b1; qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic i2c_stop();
      m_low = 1'b1; qwait();
      scl_drv = 1'b1; qwait();
      m_low = 1'b0; qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic wr_bit(input logic b);
      m_low = ~b; qwait();
      scl_drv = 1'b1; qwait();
      bit_seen = sda; qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic rd_bit(output logic b);
      m_low = 1'b0; qwait();
      scl_drv = 1'b1; qwait();
      b = sda; qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) wr_bit(d[i]);
      rd_bit(ack);
   endtask

   task automatic rd_byte(output logic [7:0] d, input logic nack);
      for (int i = 7; i >= 0; i--) rd_bit(d[i]);
      wr_bit(nack);
   endtask

   int unsigned exp_rx_cnt  = 0;
   int unsigned exp_txr_cnt = 0;
   logic [7:0]  exp_rx      = 8'h00;
   logic        ack;
   logic [7:0]  d;

   initial begin
      for (int i = 0; i < 64; i++) tx_stream[i] = 8'h00;

      // reset state
      repeat (5) @(negedge clk);
      check("rst_sda", sda, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_tx_req", tx_req, 1'b0);
      rst = 1'b1;
      qwait();

      // single write A5
      i2c_start();
      wr_byte({ADDR, 1'b0}, ack);
      check("wr_addr_ack", ack, 1'b0);
      check("wr_busy", busy, 1'b1);
      wr_byte(8'hA5, ack);
      check("wr_data_ack", ack, 1'b0);
      i2c_stop();
      exp_rx_cnt++; exp_rx = 8'hA5;
      check("wr_rx_cnt", rx_cnt, exp_rx_cnt);
      check("wr_rx_data", rx_data, exp_rx);
      check("wr_busy_after", busy, 1'b0);

      // single read 3C
      tx_stream[txr_cnt[5:0]] = 8'h3C;
      i2c_start();
      wr_byte({ADDR, 1'b1}, ack);
      check("rd_addr_ack", ack, 1'b0);
      rd_byte(d, 1'b1);
      check("rd_nack_released", bit_seen, 1'b1);
      check("rd_data", d, 8'h3C);
      i2c_stop();
      exp_txr_cnt++;
      check("rd_tx_req_cnt", txr_cnt, exp_txr_cnt);
      check("rd_busy_after", busy, 1'b0);

      // wrong address: no ack, no strobes
      i2c_start();
      wr_byte({7'h51, 1'b0}, ack);
      check("bad_addr_nack", ack, 1'b1);
      check("bad_addr_busy", busy, 1'b0);
      wr_byte(8'hFF, ack);
      check("bad_data_nack", ack, 1'b1);
      i2c_stop();
      check("bad_rx_cnt", rx_cnt, exp_rx_cnt);

      // back-to-back writes 01 then 80
      i2c_start();
      wr_byte({ADDR, 1'b0}, ack);
      wr_byte(8'h01, ack);
      check("b2b_ack0", ack, 1'b0);
      i2c_stop();
      check("b2b_busy_between", busy, 1'b0);
      check("b2b_rx0", rx_data, 8'h01);
      i2c_start();
      wr_byte({ADDR, 1'b0}, ack);
      wr_byte(8'h80, ack);
      check("b2b_ack1", ack, 1'b0);
      i2c_stop();
      exp_rx_cnt += 2; exp_rx = 8'h80;
      check("b2b_rx_cnt", rx_cnt, exp_rx_cnt);
      check("b2b_rx1", rx_data, exp_rx);

      // reset during 5th data bit of C3
      i2c_start();
      wr_byte({ADDR, 1'b0}, ack);
      wr_bit(1'b1); wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b0);
      m_low = 1'b1; qwait();
      scl_drv = 1'b1; qwait();
      rst = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_rx_valid", rx_valid, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1; qwait();
      scl_drv = 1'b0; qwait();
      i2c_stop();
      check("mid_rst_rx_cnt", rx_cnt, exp_rx_cnt);
      check("mid_rst_rx_data", rx_data, 8'h00);
      i2c_start();
      wr_byte({ADDR, 1'b0}, ack);
      wr_byte(8'h5A, ack);
      check("post_rst_ack", ack, 1'b0);
      i2c_stop();
      exp_rx_cnt++; exp_rx = 8'h5A;
      check("post_rst_rx_cnt", rx_cnt, exp_rx_cnt);
      check("post_rst_rx_data", rx_data, exp_rx);

      // reset while the slave holds the address ACK low: SDA must float at once
      i2c_start();
      for (int i = 7; i >= 1; i--) wr_bit(ADDR[i-1]);
      wr_bit(1'b0);
      m_low = 1'b0; qwait();
      scl_drv = 1'b1; qwait();
      check("ack_hold_low", sda, 1'b0);
      rst = 1'b0;
      #1;
      check("ack_rst_sda_z", sda, 1'b1);
      check("ack_rst_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1; qwait();
      scl_drv = 1'b0; qwait();
      i2c_stop();

      // two-byte read FF then 00
      tx_stream[txr_cnt[5:0]]        = 8'hFF;
      tx_stream[6'(txr_cnt + 1)]     = 8'h00;
      i2c_start();
      wr_byte({ADDR, 1'b1}, ack);
      rd_byte(d, 1'b0);
      check("rd2_byte0", d, 8'hFF);
      rd_byte(d, 1'b1);
      check("rd2_byte1", d, 8'h00);
      check("rd2_nack_released", bit_seen, 1'b1);
      i2c_stop();
      exp_txr_cnt += 2;
      check("rd2_tx_req_cnt", txr_cnt, exp_txr_cnt);

      // write then repeated START into a read
      tx_stream[txr_cnt[5:0]] = 8'h96;
      i2c_start();
      wr_byte({ADDR, 1'b0}, ack);
      wr_byte(8'h69, ack);
      i2c_start();
      check("rs_busy_cleared", busy, 1'b0);
      wr_byte({ADDR, 1'b1}, ack);
      check("rs_addr_ack", ack, 1'b0);
      rd_byte(d, 1'b1);
      check("rs_rd_data", d, 8'h96);
      i2c_stop();
      exp_rx_cnt++; exp_rx = 8'h69; exp_txr_cnt++;
      check("rs_rx_data", rx_data, exp_rx);
      check("rs_tx_req_cnt", txr_cnt, exp_txr_cnt);

      // random transactions against the model
      for (int t = 0; t < 10; t++) begin
         logic [6:0] a;
         logic       rw;
         int         n;
         logic       exp_ack;
         logic [7:0] exp_rd [0:3];
         a  = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
         rw = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 3);
         exp_ack = (a == ADDR);
         for (int k = 0; k < 4; k++) exp_rd[k] = 8'($urandom);
         for (int k = 0; k < n; k++) tx_stream[6'(txr_cnt + k)] = exp_rd[k];
         i2c_start();
         wr_byte({a, rw}, ack);
         check("rnd_addr_ack", ack, !exp_ack);
         if (exp_ack && !rw) begin
            for (int k = 0; k < n; k++) begin
               d = 8'($urandom);
               wr_byte(d, ack);
               check("rnd_wr_ack", ack, 1'b0);
               exp_rx_cnt++; exp_rx = d;
            end
         end else if (exp_ack && rw) begin
            for (int k = 0; k < n; k++) begin
               rd_byte(d, k == n - 1);
               check("rnd_rd_data", d, exp_rd[k]);
            end
            check("rnd_nack_released", bit_seen, 1'b1);
            exp_txr_cnt += n;
         end
         i2c_stop();
         check("rnd_rx_cnt", rx_cnt, exp_rx_cnt);
         check("rnd_rx_data", rx_data, exp_rx);
         check("rnd_tx_req_cnt", txr_cnt, exp_txr_cnt);
         check("rnd_busy", busy, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
